// File: rtl/hs32_div_pkg.sv
// Shared types for the hs32 divider: FSM state encoding and iteration-counter sizing.
package hs32_div_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/hs32_div_adder.sv
// Plain ripple adder with carry-in; the extra top bit of out_o is the carry-out.
module hs32_adder #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W:0]   out_o
);

  assign out_o = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};

endmodule

// File: rtl/hs32_div.sv
// Iterative restoring radix-2 divider, signed or unsigned, one quotient bit per clock.
//   state | meaning
//   IDLE  | ready for a request; operands captured on handshake
//   CALC  | WIDTH shift/subtract iterations, MSB first
//   FIX   | apply operand signs, load result registers
//   DONE  | result held until the consumer takes it
module hs32_div
  import hs32_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   trial_a;
  logic [WIDTH+1:0] trial_sum;
  logic             no_borrow;
  logic             unused_trial_msb;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;

  // Shifted partial remainder with the next dividend bit, minus the divisor.
  assign trial_a = {rem_q, quot_q[WIDTH-1]};

  hs32_adder #(.W(WIDTH + 1)) u_trial (
    .a_i   (trial_a),
    .b_i   (~{1'b0, dvsr_q}),
    .ci_i  (1'b1),
    .out_o (trial_sum)
  );

  assign no_borrow        = trial_sum[WIDTH+1];
  // An accepted difference is always below the divisor, so bit WIDTH is zero.
  assign unused_trial_msb = trial_sum[WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
            state_d     = DONE;
          end else begin
            quot_d     = dvd_mag;
            rem_d      = '0;
            dvsr_d     = dvs_mag;
            neg_quot_d = dvd_neg ^ dvs_neg;
            neg_rem_d  = dvd_neg;
            cnt_d      = '0;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        quot_d = {quot_q[WIDTH-2:0], no_borrow};
        rem_d  = no_borrow ? trial_sum[WIDTH-1:0] : trial_a[WIDTH-1:0];
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        quotient_d  = neg_quot_q ? (~quot_q + WIDTH'(1)) : quot_q;
        remainder_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
        div_zero_d  = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_hs32_div.sv
// Directed-vector bench for hs32_div at WIDTH=32 with hand-computed results.
module tb_hs32_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hs32_div #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Handshake one request, scramble inputs afterwards, count edges until rsp_valid.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    signed_op = ~s;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0000_0000;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("back_to_idle_ready", req_ready, 32'd1);
    check("back_to_idle_valid", rsp_valid, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0] = '{1'b0, 32'd100,       32'd7,       32'd14,        32'd2,        1'b0, 34};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34};
    vecs[2] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0, 34};
    vecs[3] = '{1'b0, 32'h0000_1234, 32'd0,       32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0, 34};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'd0,        1'b0, 34};
    vecs[6] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 1'b0, 34};
    vecs[7] = '{1'b0, 32'hFFFF_FFF9, 32'd2,       32'h7FFF_FFFC, 32'd1,        1'b0, 34};

    reset     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 32'd1);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_zero", div_zero, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_div_zero", i), div_zero, 32'(vecs[i].dz));
      if (i == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          check("hold_quotient", quotient, 32'd14);
          check("hold_remainder", remainder, 32'd2);
          check("hold_valid", rsp_valid, 32'd1);
          check("hold_req_ready", req_ready, 32'd0);
        end
      end
      take();
    end

    // Abort at CALC iteration 10.
    @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    pulse_reset();
    check("abort_req_ready", req_ready, 32'd1);
    check("abort_rsp_valid", rsp_valid, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_div_zero", div_zero, 32'd0);
    run_op(1'b0, 32'd9, 32'd3, lat);
    check("after_abort_latency", 32'(lat), 32'd34);
    check("after_abort_quotient", quotient, 32'd3);
    check("after_abort_remainder", remainder, 32'd0);

    // Untaken result in DONE is dropped by reset.
    pulse_reset();
    check("discard_rsp_valid", rsp_valid, 32'd0);
    check("discard_req_ready", req_ready, 32'd1);
    check("discard_quotient", quotient, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
